// File: rtl/mm_seq_pkg.sv
// Shared types and width helpers for the matmul sequencer.
// Optional build macro: MM_SEQ_PSUM_EN enables partial-sum reads.
package mm_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mm_valid_pipe.sv
// Fixed-latency valid delay line matching the systolic array depth.
// empty_o looks one cycle ahead: it is high when the line drains next edge.
module mm_valid_pipe #(
  parameter int SA_LAT = 8
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic valid_i,
  output logic valid_o,
  output logic empty_o
);

  logic [SA_LAT-1:0] line_q;
  logic [SA_LAT-1:0] line_d;

  generate
    if (SA_LAT == 1) begin : g_one
      assign line_d = valid_i;
    end else begin : g_many
      assign line_d = {line_q[SA_LAT-2:0], valid_i};
    end
  endgenerate

  assign valid_o = line_q[SA_LAT-1];
  assign empty_o = ~|line_d;

  // shift beat tags toward the writeback end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) line_q <= '0;
    else         line_q <= line_d;
  end

endmodule

// File: rtl/mm_sequencer.sv
// Matmul control sequencer: weight load, input stream, writeback.
// Define MM_SEQ_PSUM_EN to stream partial sums from the PS buffer.
module mm_sequencer
  import mm_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ROW    = 4,
  parameter int COL    = 4,
  parameter int W_SIZE = 256,
  parameter int I_SIZE = 256,
  parameter int O_SIZE = 256,
  parameter int SA_LAT = ROW + COL
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        start_i,
  input  logic [addr_w(W_SIZE)-1:0]   w_base_i,
  input  logic [addr_w(I_SIZE)-1:0]   i_base_i,
  input  logic [addr_w(W_SIZE)-1:0]   p_base_i,
  input  logic [addr_w(O_SIZE)-1:0]   o_base_i,
  input  logic [cnt_w(I_SIZE)-1:0]    len_i,
  output logic                        wb_mem_cenb_o,
  output logic                        wb_mem_wenb_o,
  output logic [addr_w(W_SIZE)-1:0]   wb_mem_addr_o,
  input  logic [COL*WIDTH-1:0]        wb_mem_data_i,
  output logic                        ib_mem_cenb_o,
  output logic                        ib_mem_wenb_o,
  output logic [addr_w(I_SIZE)-1:0]   ib_mem_addr_o,
  input  logic [ROW*WIDTH-1:0]        ib_mem_data_i,
  output logic                        ps_mem_cenb_o,
  output logic                        ps_mem_wenb_o,
  output logic [addr_w(W_SIZE)-1:0]   ps_mem_addr_o,
  input  logic [COL*WIDTH-1:0]        ps_mem_data_i,
  output logic                        ob_mem_cenb_o,
  output logic                        ob_mem_wenb_o,
  output logic [addr_w(O_SIZE)-1:0]   ob_mem_addr_o,
  output logic [COL*WIDTH-1:0]        ob_mem_data_o,
  output logic                        sa_weight_en_o,
  output logic [COL*WIDTH-1:0]        sa_weight_o,
  output logic                        sa_valid_o,
  output logic [ROW*WIDTH-1:0]        sa_input_o,
  output logic [COL*WIDTH-1:0]        sa_psum_o,
  input  logic [COL*WIDTH-1:0]        sa_result_i,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int WA = addr_w(W_SIZE);
  localparam int IA = addr_w(I_SIZE);
  localparam int OA = addr_w(O_SIZE);
  localparam int CW = cnt_w(I_SIZE);

  state_e          state_q, state_d;
  logic            start_q, start_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [WA-1:0]   w_base_q, w_base_d;
  logic [IA-1:0]   i_base_q, i_base_d;
  logic [OA-1:0]   o_base_q, o_base_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            wb_cenb_q, wb_cenb_d;
  logic [WA-1:0]   wb_addr_q, wb_addr_d;
  logic            ib_cenb_q, ib_cenb_d;
  logic [IA-1:0]   ib_addr_q, ib_addr_d;
  logic            wen_q, wen_d;
  logic            val_q, val_d;
  logic [OA-1:0]   ob_addr_q, ob_addr_d;
`ifdef MM_SEQ_PSUM_EN
  logic [WA-1:0]   p_base_q, p_base_d;
  logic            ps_cenb_q, ps_cenb_d;
  logic [WA-1:0]   ps_addr_q, ps_addr_d;
`endif

  logic            wr;
  logic            pipe_empty;
  logic            start_edge;
  logic [CW-1:0]   len_sat;
  logic [OA-1:0]   ob_now;

  mm_valid_pipe #(.SA_LAT(SA_LAT)) u_pipe (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (val_q),
    .valid_o (wr),
    .empty_o (pipe_empty)
  );

  assign start_edge = start_i & ~start_q;
  assign len_sat    = (len_i > CW'(I_SIZE)) ? CW'(I_SIZE) : len_i;
  assign ob_now     = o_base_q + OA'(wcnt_q);

  // next-state and next-output computation for the run sequencer
  always_comb begin
    state_d   = state_q;
    start_d   = start_i;
    w_base_d  = w_base_q;
    i_base_d  = i_base_q;
    o_base_d  = o_base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q + CW'(wr);
    wb_cenb_d = 1'b1;
    wb_addr_d = wb_addr_q;
    ib_cenb_d = 1'b1;
    ib_addr_d = ib_addr_q;
    wen_d     = ~wb_cenb_q;
    val_d     = ~ib_cenb_q;
    ob_addr_d = wr ? ob_now : ob_addr_q;
`ifdef MM_SEQ_PSUM_EN
    p_base_d  = p_base_q;
    ps_cenb_d = 1'b1;
    ps_addr_d = ps_addr_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          w_base_d = w_base_i;
          i_base_d = i_base_i;
          o_base_d = o_base_i;
          len_d    = len_sat;
          cnt_d    = '0;
          wcnt_d   = '0;
`ifdef MM_SEQ_PSUM_EN
          p_base_d = p_base_i;
`endif
          state_d  = (len_sat == '0) ? S_DONE : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        wb_cenb_d = 1'b0;
        wb_addr_d = w_base_q + WA'(cnt_q);
        if (cnt_q == CW'(ROW - 1)) begin
          cnt_d   = '0;
          state_d = S_STREAM;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        ib_cenb_d = 1'b0;
        ib_addr_d = i_base_q + IA'(cnt_q);
`ifdef MM_SEQ_PSUM_EN
        ps_cenb_d = 1'b0;
        ps_addr_d = p_base_q + WA'(cnt_q);
`endif
        if (cnt_q == len_q - 1'b1) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (pipe_empty && (wcnt_d == len_q)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_IDLE) || (state_d == S_DONE);
    busy_d = ~done_d;
  end

  // single register bank for FSM state and registered controls
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      done_q    <= 1'b1;
      busy_q    <= 1'b0;
      w_base_q  <= '0;
      i_base_q  <= '0;
      o_base_q  <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      wb_cenb_q <= 1'b1;
      wb_addr_q <= '0;
      ib_cenb_q <= 1'b1;
      ib_addr_q <= '0;
      wen_q     <= 1'b0;
      val_q     <= 1'b0;
      ob_addr_q <= '0;
`ifdef MM_SEQ_PSUM_EN
      p_base_q  <= '0;
      ps_cenb_q <= 1'b1;
      ps_addr_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      w_base_q  <= w_base_d;
      i_base_q  <= i_base_d;
      o_base_q  <= o_base_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      wb_cenb_q <= wb_cenb_d;
      wb_addr_q <= wb_addr_d;
      ib_cenb_q <= ib_cenb_d;
      ib_addr_q <= ib_addr_d;
      wen_q     <= wen_d;
      val_q     <= val_d;
      ob_addr_q <= ob_addr_d;
`ifdef MM_SEQ_PSUM_EN
      p_base_q  <= p_base_d;
      ps_cenb_q <= ps_cenb_d;
      ps_addr_q <= ps_addr_d;
`endif
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign wb_mem_cenb_o  = wb_cenb_q;
  assign wb_mem_wenb_o  = 1'b1;
  assign wb_mem_addr_o  = wb_addr_q;
  assign ib_mem_cenb_o  = ib_cenb_q;
  assign ib_mem_wenb_o  = 1'b1;
  assign ib_mem_addr_o  = ib_addr_q;
  assign ps_mem_wenb_o  = 1'b1;
  assign sa_weight_en_o = wen_q;
  assign sa_weight_o    = wen_q ? wb_mem_data_i : '0;
  assign sa_valid_o     = val_q;
  assign sa_input_o     = val_q ? ib_mem_data_i : '0;
  assign ob_mem_cenb_o  = ~wr;
  assign ob_mem_wenb_o  = ~wr;
  assign ob_mem_addr_o  = wr ? ob_now : ob_addr_q;
  assign ob_mem_data_o  = wr ? sa_result_i : '0;

`ifdef MM_SEQ_PSUM_EN
  assign ps_mem_cenb_o  = ps_cenb_q;
  assign ps_mem_addr_o  = ps_addr_q;
  assign sa_psum_o      = val_q ? ps_mem_data_i : '0;
`else
  logic unused_ps;
  assign unused_ps      = ^{p_base_i, ps_mem_data_i};
  assign ps_mem_cenb_o  = 1'b1;
  assign ps_mem_addr_o  = '0;
  assign sa_psum_o      = '0;
`endif

endmodule

// File: tb/tb_mm_sequencer.sv
// Self-checking bench for mm_sequencer with SRAM and array models.
// Honours MM_SEQ_PSUM_EN the same way the design does.
module tb_mm_sequencer;

  localparam int ROW = 4;
  localparam int LAT = 8;
  localparam int DEP = 256;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic        clk = 0;
  logic        rstn_i = 0;
  logic        start_i = 0;
  logic [7:0]  w_base_i = 0, i_base_i = 0, p_base_i = 0, o_base_i = 0;
  logic [8:0]  len_i = 0;
  logic        wb_cenb, wb_wenb, ib_cenb, ib_wenb;
  logic        ps_cenb, ps_wenb, ob_cenb, ob_wenb;
  logic [7:0]  wb_addr, ib_addr, ps_addr, ob_addr;
  logic [31:0] wb_rd = 0, ib_rd = 0, ps_rd = 0, ob_data;
  logic        sa_wen, sa_valid, busy_o, done_o;
  logic [31:0] sa_weight, sa_input, sa_psum, sa_result;

  logic [31:0] wbm [DEP];
  logic [31:0] ibm [DEP];
  logic [31:0] psm [DEP];
  logic [31:0] sa_pipe [LAT];

  ev_t wbq[$], wenq[$], ibq[$], psq[$], valq[$], obq[$];
  int  doneq[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  wenb_bad = 0;
  bit  done_prev = 1;

  mm_sequencer dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i),
    .w_base_i(w_base_i), .i_base_i(i_base_i),
    .p_base_i(p_base_i), .o_base_i(o_base_i), .len_i(len_i),
    .wb_mem_cenb_o(wb_cenb), .wb_mem_wenb_o(wb_wenb),
    .wb_mem_addr_o(wb_addr), .wb_mem_data_i(wb_rd),
    .ib_mem_cenb_o(ib_cenb), .ib_mem_wenb_o(ib_wenb),
    .ib_mem_addr_o(ib_addr), .ib_mem_data_i(ib_rd),
    .ps_mem_cenb_o(ps_cenb), .ps_mem_wenb_o(ps_wenb),
    .ps_mem_addr_o(ps_addr), .ps_mem_data_i(ps_rd),
    .ob_mem_cenb_o(ob_cenb), .ob_mem_wenb_o(ob_wenb),
    .ob_mem_addr_o(ob_addr), .ob_mem_data_o(ob_data),
    .sa_weight_en_o(sa_wen), .sa_weight_o(sa_weight),
    .sa_valid_o(sa_valid), .sa_input_o(sa_input),
    .sa_psum_o(sa_psum), .sa_result_i(sa_result),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fa(input logic [31:0] x, input logic [31:0] p);
    return (x * 32'd3 + p) ^ 32'hA5C3_1E77;
  endfunction

  function automatic ev_t mk(input int c, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.cyc = c;
    e.a = a;
    e.d = d;
    return e;
  endfunction

  // synchronous SRAMs and an array whose result depends on the beat
  always @(posedge clk) begin
    if (!wb_cenb) wb_rd <= wbm[wb_addr];
    if (!ib_cenb) ib_rd <= ibm[ib_addr];
    if (!ps_cenb) ps_rd <= psm[ps_addr];
    for (int i = LAT - 1; i > 0; i--) sa_pipe[i] <= sa_pipe[i-1];
    sa_pipe[0] <= fa(sa_input, sa_psum);
  end
  assign sa_result = sa_pipe[LAT-1];

  // event log sampled mid-cycle
  always @(negedge clk) begin
    if (rstn_i) begin
      if (!wb_cenb) wbq.push_back(mk(cyc, 32'(wb_addr), 0));
      if (sa_wen) wenq.push_back(mk(cyc, 0, sa_weight));
      if (!ib_cenb) ibq.push_back(mk(cyc, 32'(ib_addr), 0));
      if (!ps_cenb) psq.push_back(mk(cyc, 32'(ps_addr), 0));
      if (sa_valid) valq.push_back(mk(cyc, sa_input, sa_psum));
      if (!ob_cenb && !ob_wenb) obq.push_back(mk(cyc, 32'(ob_addr), ob_data));
      if (!wb_wenb || !ib_wenb || !ps_wenb) wenb_bad++;
      if (done_o && !done_prev) doneq.push_back(cyc);
    end
    done_prev = done_o;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wbq.delete(); wenq.delete(); ibq.delete(); psq.delete();
    valq.delete(); obq.delete(); doneq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"},
          {done_o, busy_o, wb_cenb, ib_cenb, ps_cenb, ob_cenb,
           wb_wenb, ib_wenb, ps_wenb, ob_wenb, sa_valid, sa_wen},
          12'b10_1111_1111_00);
    check({tag, "_data"}, {sa_input, sa_weight}, 0);
    check({tag, "_data2"}, {sa_psum, ob_data}, 0);
    check({tag, "_addr"}, {wb_addr, ib_addr, ps_addr, ob_addr}, 0);
  endtask

  task automatic run(input int wb, input int ib, input int pb, input int ob,
                     input int len, input bit hold, input bit mid);
    int es, ln, bound, k;
    logic [31:0] pexp;
    ln = (len > DEP) ? DEP : len;
    clear_logs();
    step();
    w_base_i = 8'(wb); i_base_i = 8'(ib);
    p_base_i = 8'(pb); o_base_i = 8'(ob);
    len_i = 9'(len);
    start_i = 1;
    es = cyc + 1;
    step();
    if (!hold) start_i = 0;
    if (ln == 0) begin
      check("len0_done", {busy_o, done_o}, 2'b01);
      repeat (4) step();
      check("len0_access", wbq.size() + ibq.size() + psq.size()
            + obq.size() + valq.size() + wenq.size() + doneq.size(), 0);
      return;
    end
    step();
    check("run_busy", {busy_o, done_o}, 2'b10);
    bound = ROW + ln + LAT + 20;
    for (int t = 0; t < bound && doneq.size() == 0; t++) begin
      step();
      if (mid && !hold) start_i = (cyc == es + ROW + 1);
    end
    start_i = hold;
    check("done_seen", doneq.size(), 1);
    if (doneq.size() == 0) return;
    check("done_cyc", doneq[0], es + ROW + 2 + ln + LAT);
    repeat (3) step();
    check("wb_cnt", wbq.size(), ROW);
    check("wen_cnt", wenq.size(), ROW);
    for (k = 0; k < ROW && k < wbq.size() && k < wenq.size(); k++) begin
      check("wb_cyc", wbq[k].cyc, es + 1 + k);
      check("wb_addr", wbq[k].a, (wb + k) % DEP);
      check("wen_cyc", wenq[k].cyc, es + 2 + k);
      check("wen_data", wenq[k].d, wbm[(wb + k) % DEP]);
    end
    check("ib_cnt", ibq.size(), ln);
    check("val_cnt", valq.size(), ln);
    check("ob_cnt", obq.size(), ln);
`ifdef MM_SEQ_PSUM_EN
    check("ps_cnt", psq.size(), ln);
`else
    check("ps_cnt", psq.size(), 0);
`endif
    check("wenb_tied", wenb_bad, 0);
    for (k = 0; k < ln && k < ibq.size() && k < valq.size() && k < obq.size(); k++) begin
`ifdef MM_SEQ_PSUM_EN
      pexp = psm[(pb + k) % DEP];
      if (k < psq.size()) begin
        check("ps_cyc", psq[k].cyc, es + ROW + 1 + k);
        check("ps_addr", psq[k].a, (pb + k) % DEP);
      end
`else
      pexp = 0;
`endif
      check("ib_cyc", ibq[k].cyc, es + ROW + 1 + k);
      check("ib_addr", ibq[k].a, (ib + k) % DEP);
      check("val_cyc", valq[k].cyc, es + ROW + 2 + k);
      check("val_in", valq[k].a, ibm[(ib + k) % DEP]);
      check("val_ps", valq[k].d, pexp);
      check("ob_cyc", obq[k].cyc, es + ROW + 2 + k + LAT);
      check("ob_addr", obq[k].a, (ob + k) % DEP);
      check("ob_data", obq[k].d, fa(ibm[(ib + k) % DEP], pexp));
    end
  endtask

  initial begin
    int es;
    for (int i = 0; i < DEP; i++) begin
      wbm[i] = $urandom;
      ibm[i] = $urandom;
      psm[i] = $urandom;
    end
    for (int i = 0; i < LAT; i++) sa_pipe[i] = 0;

    repeat (3) step();
    check_reset_outputs("reset");
    rstn_i = 1;
    repeat (2) step();
    check_reset_outputs("post_reset");

    run(16, 0, 51, 32, 3, 0, 0);
    run(int'($urandom_range(255, 0)), 254, 250, 255, 4, 0, 0);
    run(7, 9, 11, 13, 0, 0, 0);

    run(16, 0, 51, 32, 3, 1, 0);
    clear_logs();
    repeat (6) step();
    check("hold_norerun", wbq.size() + ibq.size() + obq.size(), 0);
    check("hold_done", done_o, 1'b1);
    start_i = 0;
    step();
    run(16, 0, 51, 32, 3, 0, 0);

    run(100, 40, 60, 200, 8, 0, 1);

    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
          int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
          int'($urandom_range(40, 1)), 0, 0);

    run(3, 128, 77, 250, 300, 0, 0);

    clear_logs();
    step();
    w_base_i = 8'd5; i_base_i = 8'd6; o_base_i = 8'd7; len_i = 9'd10;
    start_i = 1;
    es = cyc + 1;
    step();
    start_i = 0;
    for (int t = 0; t < 40 && cyc < es + ROW + 4; t++) step();
    check("rst_in_stream", valq.size() > 0, 1'b1);
    rstn_i = 0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) step();
    rstn_i = 1;
    clear_logs();
    repeat (LAT + 6) step();
    check("rst_no_write", obq.size() + wbq.size() + ibq.size(), 0);
    check("rst_done", {busy_o, done_o}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
